if_fetch_unit: RTL
==================

# if_fetch_unit

Parametrised front-end fetch stage for the rv32 superscalar core. Issues one aligned FETCH_WIDTH-instruction block request at a time to instruction memory, predecodes JAL and predicted-taken branches, and pushes a masked packet into the instruction queue. Unlike the previous fetch stage, a response that meets a full queue is parked in a one-packet hold register rather than refetched. A flush that arrives while a request is in flight is handled by a discard state.

## Interface
Parameters:
- FETCH_WIDTH, 2: instructions per fetch block; power of 2, range 1..8.
- RESET_PC, 32'h60000000: first fetch PC.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- imem_addr  out  32  block address, aligned to FETCH_WIDTH*4.
- imem_rmask  out  4  '1 = request valid; '0 = no request.
- imem_resp  in  1  response for the outstanding request.
- imem_rdata  in  32*FETCH_WIDTH  block data; slot i is bits [32i+:32].
- instr_queue_input  out  pc_instr_t[FETCH_WIDTH]  packet; each slot carries valid, pc, instruction and br_taken_pred.
- instr_queue_push  out  1  push strobe.
- instr_queue_full  in  1  queue cannot accept a push this cycle.
- mispredict  in  1  flush and redirect.
- br_PC  in  brq_entry_t  redirect target; only .branch_pc is used.
- br_taken  in  FETCH_WIDTH  per-slot direction prediction.

## Operation
States:
- FETCH: request outstanding.
- DISCARD: outstanding response is stale.
- HOLD: packet is parked and no request is outstanding.

Registers: pc (next instruction to deliver), redir_pc, hold packet plus hold_next_pc.

Block address: blk(pc) = {pc[31:log2(FETCH_WIDTH)+2], 0}.

Slot rules:
- A slot is valid if blk + 4i >= pc.
- The first valid slot that is JAL, or is a branch with br_taken[i]=1, terminates the packet. That slot gets br_taken_pred=1 and later slots are invalid.
- The next PC is that slot's target: slot pc plus J-imm or B-imm, 32-bit wrapping add.
- Otherwise the next PC is blk + FETCH_WIDTH*4. JALR is predicted sequential.
- Invalid slots are driven all zero.

Transitions. Mispredict has the highest priority.
- FETCH, resp, !mispredict, !full: push the packet, pc <= next, and issue the next request in the same cycle.
- FETCH, resp, !mispredict, full: capture the packet into hold, go to HOLD, rmask='0.
- FETCH, resp, mispredict: drop the data, pc <= branch_pc, request blk(branch_pc) in the same cycle, stay in FETCH.
- FETCH, !resp, mispredict: redir_pc <= branch_pc, go to DISCARD, keep the address stable.
- DISCARD, mispredict (with or without resp): redir_pc <= branch_pc; the latest redirect wins.
- DISCARD, resp: drop the data, pc <= redir_pc (or branch_pc if mispredict is also asserted), request that block in the same cycle, go to FETCH.
- HOLD, mispredict: drop the hold, pc <= branch_pc, request it, go to FETCH.
- HOLD, !full: push the hold packet, pc <= hold_next_pc, request it, go to FETCH.

Memory request rules:
- imem_addr and imem_rmask stay constant while a request is outstanding.
- They may change only in a resp cycle, or in the cycle a request is launched from HOLD or from reset.

## Timing
- Reset: state=FETCH, pc=RESET_PC, instr_queue_push=0, imem_rmask='0 while rst is high.
- First cycle after reset: imem_addr=blk(RESET_PC), imem_rmask='1.
- Push is combinational in the resp cycle: 0-cycle latency from imem_resp to instr_queue_push.
- From HOLD: push occurs in the first cycle with full=0.
- Back-to-back responses sustain one block per cycle.
- Redirect during an outstanding request costs one discarded response.
- Reset mid-request: outstanding data is ignored. The memory is expected to be reset in the same cycle.
- instr_queue_push is never asserted in DISCARD, or in any cycle with mispredict=1.

## Configuration
- IF_PERF_CNT_EN defined: adds output ports perf_fetch_cnt, perf_stall_cnt and perf_flush_cnt, each 32 bits, wrapping, cleared by rst.
  - perf_fetch_cnt counts pushes.
  - perf_stall_cnt counts cycles spent in HOLD.
  - perf_flush_cnt counts mispredict cycles.
- Undefined: the ports and counters are absent; function is identical otherwise.

## Structure
- rv32i_types, existing: pc_instr_t, brq_entry_t, op_jal, op_br.
- rv32i_types, additions: if_state_t enum {IF_FETCH, IF_DISCARD, IF_HOLD}, FETCH_WIDTH_BITS helper.
- Sub-module if_predecode is combinational. Inputs: rdata, blk, pc, br_taken. Outputs: slot mask, br_taken_pred vector, next PC.

## Test plan
Defaults FETCH_WIDTH=2, RESET_PC=0x60000000.
- Reset, memory returns NOPs at 1-cycle latency, full=0. Required: addresses 0x60000000, 0x60000008, 0x60000010; push every resp cycle with both slots valid.
- Redirect to 0x60000104 with the following response returning two NOPs. Required: imem_addr=0x60000100; slot0 invalid; slot1 pc=0x60000104.
- Slot0 holds JAL +0x20 at 0x60000000. Required: slot1 invalid, slot0 br_taken_pred=1, next imem_addr=0x60000020.
- Queue full during resp for 3 cycles. Required: HOLD with rmask='0, no duplicate request, and exactly one push of identical data when full drops.
- Mispredict to 0x60000200 mid-request, then a second mispredict to 0x60000300 before resp. Required: stale data not pushed; next request 0x60000300.
- Mispredict in the same cycle as resp, and mispredict while in HOLD. Required in both cases: no push and a same-cycle request to blk(branch_pc).

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared type definitions for the rv32 core front end.
//
// Contents:
//   rv32i_opcode      - base opcode encodings (op_jal, op_br, ...)
//   pc_instr_t        - one instruction-queue slot: valid, pc, instr, br_taken_pred
//   brq_entry_t       - branch-queue entry; fetch only consumes .branch_pc
//   if_state_t        - fetch-stage state encoding
//   FETCH_WIDTH_BITS  - log2 of the fetch width (block offset bits minus 2)
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        br_taken_pred;
    } pc_instr_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] branch_pc;
        logic [31:0] target_pc;
        logic        taken;
    } brq_entry_t;

    typedef enum logic [1:0] {
        IF_FETCH,
        IF_DISCARD,
        IF_HOLD
    } if_state_t;

    function automatic int unsigned FETCH_WIDTH_BITS(input int unsigned fetch_width);
        return $clog2(fetch_width);
    endfunction

endpackage

// File: rtl/if_predecode.sv
// if_predecode: combinational predecode of one fetch block.
//
// Ports:
//   rdata      in   block data, slot i at bits [32i+:32]
//   blk        in   aligned block address
//   pc         in   first pc to deliver within the block
//   br_taken   in   per-slot direction prediction for conditional branches
//   slot_mask  out  slots to deliver
//   taken_pred out  one-hot slot that redirects fetch (JAL or predicted-taken branch)
//   next_pc    out  pc of the instruction following this packet
module if_predecode
    import rv32i_types::*;
#(
    parameter int unsigned FETCH_WIDTH = 2
) (
    input  logic [32*FETCH_WIDTH-1:0] rdata,
    input  logic [31:0]               blk,
    input  logic [31:0]               pc,
    input  logic [FETCH_WIDTH-1:0]    br_taken,
    output logic [FETCH_WIDTH-1:0]    slot_mask,
    output logic [FETCH_WIDTH-1:0]    taken_pred,
    output logic [31:0]               next_pc
);

    localparam logic [31:0] BLK_BYTES = 32'(FETCH_WIDTH * 4);

    logic [31:0] instr;
    logic [31:0] slot_pc;
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic        is_jal;
    logic        is_br_taken;
    logic        stop;

    always_comb begin
        slot_mask   = '0;
        taken_pred  = '0;
        next_pc     = blk + BLK_BYTES;
        stop        = 1'b0;
        instr       = '0;
        slot_pc     = '0;
        j_imm       = '0;
        b_imm       = '0;
        is_jal      = 1'b0;
        is_br_taken = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            instr       = rdata[32*i +: 32];
            slot_pc     = blk + 32'(4 * i);
            j_imm       = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            b_imm       = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            is_jal      = (instr[6:0] == op_jal);
            is_br_taken = (instr[6:0] == op_br) && br_taken[i];
            // Slots before pc belong to an earlier packet (redirect into mid-block);
            // the first redirecting slot ends the packet.
            if (!stop && (slot_pc >= pc)) begin
                slot_mask[i] = 1'b1;
                if (is_jal || is_br_taken) begin
                    taken_pred[i] = 1'b1;
                    next_pc       = slot_pc + (is_jal ? j_imm : b_imm);
                    stop          = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: front-end fetch stage. Fetches one aligned block at a time,
// predecodes JAL / predicted-taken branches and pushes a masked packet into
// the instruction queue. A response that meets a full queue is parked in a
// one-packet hold register; a redirect during an outstanding request is
// absorbed by discarding that request's response.
//
// Optional build macro: IF_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt /
// perf_flush_cnt (pushes, HOLD cycles, mispredict cycles).
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   imem_addr/rmask    block request; held stable while outstanding
//   imem_resp/rdata    response for the outstanding request
//   instr_queue_*      packet, push strobe, full back-pressure
//   mispredict, br_PC  flush and redirect to br_PC.branch_pc
//   br_taken           per-slot direction prediction
//
// state      | meaning
// IF_FETCH   | request outstanding, response will be used
// IF_DISCARD | request outstanding, response is stale (redirect pending)
// IF_HOLD    | packet parked in hold register, no request outstanding
module if_fetch_unit
    import rv32i_types::*;
#(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter logic [31:0] RESET_PC    = 32'h60000000
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [31:0]               imem_addr,
    output logic [3:0]                imem_rmask,
    input  logic                      imem_resp,
    input  logic [32*FETCH_WIDTH-1:0] imem_rdata,
    output pc_instr_t                 instr_queue_input [FETCH_WIDTH],
    output logic                      instr_queue_push,
    input  logic                      instr_queue_full,
    input  logic                      mispredict,
    input  brq_entry_t                br_PC,
    input  logic [FETCH_WIDTH-1:0]    br_taken
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]               perf_fetch_cnt,
    output logic [31:0]               perf_stall_cnt,
    output logic [31:0]               perf_flush_cnt
`endif
);

    localparam int unsigned OFS = FETCH_WIDTH_BITS(FETCH_WIDTH) + 2;

    function automatic logic [31:0] blk_of(input logic [31:0] a);
        return {a[31:OFS], {OFS{1'b0}}};
    endfunction

    if_state_t   state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] redir_pc, redir_d;
    logic [31:0] hold_next_pc;
    pc_instr_t   hold_pkt  [FETCH_WIDTH];
    pc_instr_t   fresh_pkt [FETCH_WIDTH];
    logic        hold_load;

    logic [31:0]            blk_pc;
    logic [FETCH_WIDTH-1:0] pd_mask;
    logic [FETCH_WIDTH-1:0] pd_taken;
    logic [31:0]            pd_next_pc;

    logic unused_br_fields;
    assign unused_br_fields = ^{br_PC.valid, br_PC.target_pc, br_PC.taken};

    assign blk_pc = blk_of(pc);

    if_predecode #(.FETCH_WIDTH(FETCH_WIDTH)) u_predecode (
        .rdata      (imem_rdata),
        .blk        (blk_pc),
        .pc         (pc),
        .br_taken   (br_taken),
        .slot_mask  (pd_mask),
        .taken_pred (pd_taken),
        .next_pc    (pd_next_pc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IF_FETCH;
            pc       <= RESET_PC;
            redir_pc <= RESET_PC;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            redir_pc <= redir_d;
        end
    end

    always_ff @(posedge clk) begin
        if (hold_load) begin
            hold_pkt     <= fresh_pkt;
            hold_next_pc <= pd_next_pc;
        end
    end

    // Next state. pc_d always names the pc whose block is being requested,
    // so the request address can be derived from it directly.
    always_comb begin
        state_d   = state;
        pc_d      = pc;
        redir_d   = redir_pc;
        hold_load = 1'b0;
        case (state)
            IF_FETCH: begin
                if (mispredict) begin
                    if (imem_resp) begin
                        pc_d = br_PC.branch_pc;
                    end else begin
                        redir_d = br_PC.branch_pc;
                        state_d = IF_DISCARD;
                    end
                end else if (imem_resp) begin
                    if (instr_queue_full) begin
                        hold_load = 1'b1;
                        state_d   = IF_HOLD;
                    end else begin
                        pc_d = pd_next_pc;
                    end
                end
            end
            IF_DISCARD: begin
                if (mispredict) begin
                    redir_d = br_PC.branch_pc;
                end
                if (imem_resp) begin
                    pc_d    = mispredict ? br_PC.branch_pc : redir_pc;
                    state_d = IF_FETCH;
                end
            end
            IF_HOLD: begin
                if (mispredict) begin
                    pc_d    = br_PC.branch_pc;
                    state_d = IF_FETCH;
                end else if (!instr_queue_full) begin
                    pc_d    = hold_next_pc;
                    state_d = IF_FETCH;
                end
            end
            default: state_d = IF_FETCH;
        endcase
    end

    // Outputs
    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            fresh_pkt[i] = '0;
            if (pd_mask[i]) begin
                fresh_pkt[i].valid         = 1'b1;
                fresh_pkt[i].pc            = blk_pc + 32'(4 * i);
                fresh_pkt[i].instr         = imem_rdata[32*i +: 32];
                fresh_pkt[i].br_taken_pred = pd_taken[i];
            end
        end

        for (int i = 0; i < FETCH_WIDTH; i++) begin
            instr_queue_input[i] = (state == IF_HOLD) ? hold_pkt[i] : fresh_pkt[i];
        end

        instr_queue_push = !rst && !mispredict && !instr_queue_full &&
                           (((state == IF_FETCH) && imem_resp) || (state == IF_HOLD));

        imem_addr  = blk_of(pc_d);
        imem_rmask = (rst || (state_d == IF_HOLD)) ? 4'h0 : 4'hF;
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (instr_queue_push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (state == IF_HOLD) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (mispredict)       perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
